reorder_tag_issuer: RTL
=======================

Name: reorder_tag_issuer

Overview:
- Front end of the reordering path. Assigns a wrapping sequence tag to every request before it goes out to out-of-order servers.
- Limits in-flight requests to DEPTH, so the downstream reordering FIFO can never overflow.
- Takes retire pulses, with tags, from the reordering FIFO read side and checks that they come back in order.
- Provides a drain-then-restart soft reset.

Parameters:
- WID, 32, payload width.
- DEPTH, 8, max outstanding tags; must match the reordering FIFO depth; power of 2.
- AWID, $clog2(DEPTH), tag is AWID+1 bits; tags wrap at 2*DEPTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- softreset  input  1  pulse: drain, then restart tag sequence at 0
- vldin  input  1  upstream request valid
- din  input  WID  upstream payload
- readyin  output  1  upstream accept
- vldout  output  1  issued request valid
- dout  output  WID  issued payload (registered)
- tagout  output  AWID+1  tag of issued request (registered)
- readyout  input  1  downstream accept
- retire  input  1  pulse: one entry popped by the reordering FIFO
- retire_tag  input  AWID+1  tag of the popped entry
- count  output  16  outstanding tags, zero-extended
- draining  output  1  high in DRAIN state
- err_underflow  output  1  sticky: retire seen with count==0
- err_order  output  1  sticky: retire_tag != expected tag

Behaviour:
- Reset (rst_n low at posedge): state=RUN, wtag=0, rtag=0, outstanding=0, vldout=0, dout=0, tagout=0, err_underflow=0, err_order=0. readyin is 0 while rst_n is low.
- readyin is combinational = (state==RUN) && (outstanding<DEPTH) && (!vldout || readyout).
- A retire in the same cycle does NOT raise readyin. No combinational path from retire to readyin.
- Accept: vldin && readyin at a posedge. Then:
  - dout<=din, tagout<=wtag, vldout<=1.
  - wtag <= (wtag==2*DEPTH-1) ? 0 : wtag+1.
  - Latency: 1 cycle from accept to vldout.
- Output holding: vldout, dout and tagout hold until vldout && readyout. vldout clears on a handshake with no new accept in the same cycle.
- Back-to-back: handshake and new accept in the same cycle give full throughput.
- outstanding:
  - +1 on accept, -1 on valid retire, unchanged when both happen.
  - Range 0..DEPTH. count = outstanding zero-extended to 16 bits.
- Retire with outstanding==0: ignored (no decrement, rtag unchanged), err_underflow<=1.
- Retire with outstanding>0:
  - Compare retire_tag against rtag. On mismatch, err_order<=1; the retire still counts.
  - rtag advances with the same wrap as wtag.
- Full boundary: outstanding==DEPTH gives readyin=0. The cycle after a retire, readyin may rise.
- States:
  - RUN: normal operation. softreset moves to DRAIN.
  - DRAIN: readyin=0, draining=1. The held output still completes its handshake, and retires are still processed. When outstanding==0 && !vldout: wtag<=0, rtag<=0, both errors cleared, next state RUN.
  - softreset in DRAIN: no effect.
  - softreset in RUN with outstanding==0 and !vldout: one DRAIN cycle, then RUN.
- rst_n low at any time, including mid-DRAIN or with vldout held: immediate return to the reset values above. No handshake is completed.
- Tag-wrap invariant: wtag - rtag (mod 2*DEPTH) == outstanding whenever no error has occurred.

Test Plan:
- DEPTH=8, readyout=1, 20 back-to-back requests, each retired 3 cycles after issue with the correct tag:
  - tagout sequence 0..15,0..3.
  - count peaks at 4.
  - No errors; readyin never drops.
- 8 requests, no retires:
  - count=8 and readyin=0 from the cycle after the 8th accept.
  - One retire(tag 0): readyin=1 the next cycle.
  - 9th request gets tag 8.
- readyout=0 for 5 cycles with vldin=1:
  - dout/tagout stable, readyin=0.
  - Second request accepted in the same cycle readyout rises; no loss or duplication.
- retire with count==0: err_underflow=1, count stays 0. retire_tag=3 when rtag=0: err_order=1, count still decrements.
- softreset with count=3 and vldout held:
  - draining=1, readyin=0 until the held output handshakes and 3 retires arrive.
  - Then RUN; next tagout=0; errors cleared.
- rst_n low mid-DRAIN with vldout=1: next cycle vldout=0, count=0, state RUN. readyin=1 once rst_n is high.

Source files
------------

// File: rtl/reorder_tag_issuer_if.sv
// rtl/reorder_tag_issuer_if.sv - request, issue and retire signal bundle for the tag issuer
interface reorder_tag_issuer_if #(
   parameter int WID   = 32,
   parameter int DEPTH = 8
);
   localparam int AWID = $clog2(DEPTH);

   logic            vldin;
   logic [WID-1:0]  din;
   logic            readyin;
   logic            vldout;
   logic [WID-1:0]  dout;
   logic [AWID:0]   tagout;
   logic            readyout;
   logic            retire;
   logic [AWID:0]   retire_tag;

   // master is the surrounding logic: it offers requests, accepts issues and reports retires
   modport master (
      output vldin, din, readyout, retire, retire_tag,
      input  readyin, vldout, dout, tagout
   );

   // slave is the tag issuer itself
   modport slave (
      input  vldin, din, readyout, retire, retire_tag,
      output readyin, vldout, dout, tagout
   );
endinterface

// File: rtl/reorder_tag_issuer.sv
// rtl/reorder_tag_issuer.sv - sequence tag issue, in-flight limit and in-order retire check
module reorder_tag_issuer #(
   parameter int WID   = 32,
   parameter int DEPTH = 8,
   parameter int AWID  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   softreset,
   reorder_tag_issuer_if.slave    bus,
   output logic [15:0]            count,
   output logic                   draining,
   output logic                   err_underflow,
   output logic                   err_order
);
   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   localparam logic [AWID:0] DEPTH_C = (AWID+1)'(DEPTH);
   localparam logic [AWID:0] TAG_MAX = (AWID+1)'(2*DEPTH-1);
   localparam logic [AWID:0] TAG_ONE = (AWID+1)'(1);

   state_t          state;
   logic [AWID:0]   wtag;
   logic [AWID:0]   rtag;
   logic [AWID:0]   outstanding;
   logic            vld_q;
   logic [WID-1:0]  dout_q;
   logic [AWID:0]   tag_q;

   logic            accept;
   logic            handshake;
   logic            retire_ok;
   logic            drain_done;

   // readyin only looks at registered state, so a same-cycle retire cannot open the gate
   assign bus.readyin = rst_n && (state == RUN) && (outstanding < DEPTH_C) &&
                        (!vld_q || bus.readyout);

   assign accept     = bus.vldin && bus.readyin;
   assign handshake  = vld_q && bus.readyout;
   assign retire_ok  = bus.retire && (outstanding != '0);
   assign drain_done = (state == DRAIN) && (outstanding == '0) && !vld_q;

   assign bus.vldout = vld_q;
   assign bus.dout   = dout_q;
   assign bus.tagout = tag_q;
   assign count      = {{(15-AWID){1'b0}}, outstanding};
   assign draining   = (state == DRAIN);

   // issue register, tag counters, in-flight count, error flags and RUN/DRAIN control
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= RUN;
         wtag          <= '0;
         rtag          <= '0;
         outstanding   <= '0;
         vld_q         <= 1'b0;
         dout_q        <= '0;
         tag_q         <= '0;
         err_underflow <= 1'b0;
         err_order     <= 1'b0;
      end else begin
         if (accept) begin
            dout_q <= bus.din;
            tag_q  <= wtag;
            vld_q  <= 1'b1;
            wtag   <= (wtag == TAG_MAX) ? '0 : wtag + TAG_ONE;
         end else if (handshake) begin
            vld_q <= 1'b0;
         end

         if (bus.retire && (outstanding == '0)) begin
            err_underflow <= 1'b1;
         end
         if (retire_ok) begin
            if (bus.retire_tag != rtag) begin
               err_order <= 1'b1;
            end
            rtag <= (rtag == TAG_MAX) ? '0 : rtag + TAG_ONE;
         end

         case ({accept, retire_ok})
            2'b10:   outstanding <= outstanding + TAG_ONE;
            2'b01:   outstanding <= outstanding - TAG_ONE;
            default: outstanding <= outstanding;
         endcase

         case (state)
            RUN: begin
               if (softreset) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // nothing in flight and nothing held: restart the sequence from a clean slate
               if (drain_done) begin
                  wtag          <= '0;
                  rtag          <= '0;
                  err_underflow <= 1'b0;
                  err_order     <= 1'b0;
                  state         <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule
